// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER fetch stage.
package otter_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: synchronous FIFO of {pc, instr} entries with clear.
// Clear beats push; push and pop may coincide at any occupancy.
module fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (rst_n && !clr && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER fetch stage: PC, imem req/gnt/rvalid handshake, fetch queue and IF/ID register.
// Define FETCH_BYPASS_EN to let a response load IF/ID directly when the queue is empty.
module otter_fetch_unit
  import otter_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH  = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc4
);

  localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] q_count;
  logic [CW1-1:0] inflight;
  logic          req_pend;
  logic          grant;
  logic          rv;
  logic          rv_keep;
  logic          byp;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;

  // Slot budget counts the entry leaving the queue this cycle so a 2-deep queue streams
  assign q_pop    = !FlushD && !StallD && !q_empty;
  assign inflight = CW1'(q_count) + CW1'(outstanding) - CW1'(q_pop);

  assign imem_req  = RST_N && !redirect_valid &&
                     (req_pend || (!StallF && (inflight < CW1'(FQ_DEPTH))));
  assign imem_addr = pc;

  assign grant   = imem_req && imem_gnt;
  assign rv      = imem_rvalid && (outstanding != '0);
  assign rv_keep = rv && (drop == '0) && !redirect_valid;
  assign out_nxt = outstanding + CW'(grant) - CW'(rv);

`ifdef FETCH_BYPASS_EN
  assign byp = rv_keep && q_empty && !StallD && !FlushD;
`else
  assign byp = 1'b0;
`endif

  assign q_push = rv_keep && !byp;
  assign q_din  = '{pc: resp_pc, instr: imem_rdata};

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (q_push),
    .pop   (q_pop),
    .clr   (redirect_valid),
    .din   (q_din),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // PC, response tracking and stale-response drop counter
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc          <= RESET_VEC;
      resp_pc     <= RESET_VEC;
      outstanding <= '0;
      drop        <= '0;
      req_pend    <= 1'b0;
    end else begin
      assert (!(q_push && q_full && !q_pop && !redirect_valid));
      outstanding <= out_nxt;
      req_pend    <= imem_req && !imem_gnt;
      if (redirect_valid) begin
        pc      <= redirect_pc;
        resp_pc <= redirect_pc;
        drop    <= out_nxt;
      end else begin
        if (grant)                 pc      <= pc + 32'd4;
        if (rv && (drop != '0))    drop    <= drop - CW'(1);
        if (rv_keep)               resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  // IF/ID register: flush beats stall; starvation loads a bubble
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dec_valid <= 1'b0;
      dec_instr <= NOP_INSTR;
      dec_pc    <= 32'd0;
      dec_pc4   <= 32'd4;
    end else if (FlushD) begin
      dec_valid <= 1'b0;
      dec_instr <= NOP_INSTR;
    end else if (!StallD) begin
      if (!q_empty) begin
        dec_valid <= 1'b1;
        dec_instr <= q_head.instr;
        dec_pc    <= q_head.pc;
        dec_pc4   <= q_head.pc + 32'd4;
      end else if (byp) begin
        dec_valid <= 1'b1;
        dec_instr <= imem_rdata;
        dec_pc    <= resp_pc;
        dec_pc4   <= resp_pc + 32'd4;
      end else begin
        dec_valid <= 1'b0;
        dec_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: in-order imem model with random latency and grant,
// checked against a program-order reference of what decode must see.
module tb_otter_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;

  otter_fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc4(dec_pc4)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int nvalid = 0;

  // imem model: granted addresses awaiting response, and in-flight ones orphaned by reset
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] stale[$];

  // Reference: next program-order PC decode must receive, plus last observed IF/ID
  logic [31:0] exp_pc = '0;
  logic        h_valid = 1'b0;
  logic [31:0] h_instr = '0, h_pc = '0;
  logic        p_req = 1'b0;
  logic [31:0] p_addr = '0;
  logic        obs_req;
  logic [31:0] obs_addr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit sf, input bit sd, input bit fd,
                      input bit rv_en, input logic [31:0] rpc, input bit g);
    @(negedge CLK);
    RST_N = !rst; StallF = sf; StallD = sd; FlushD = fd;
    redirect_valid = rv_en; redirect_pc = rpc; imem_gnt = g;
    if (rst) begin
      while (pend_addr.size() > 0) begin
        stale.push_back(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
    if (stale.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(stale.pop_front());
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    obs_req = imem_req; obs_addr = imem_addr;
    if (rst) chk("req_in_reset", 32'(imem_req), 32'd0);
    if (p_req && !rst && !rv_en) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, p_addr);
    end
    if (imem_req && !rst) chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
    if (imem_req && g && !rst) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
    end
    p_req  = imem_req && !g && !rst && !rv_en;
    p_addr = imem_addr;
    @(posedge CLK); #1;
    cyc++;
    chk("pc4_consistent", dec_pc4, dec_pc + 32'd4);
    if (rst) begin
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_instr", dec_instr, NOP);
      chk("rst_pc", dec_pc, 32'd0);
      exp_pc = 32'd0;
    end else if (fd) begin
      chk("flush_valid", 32'(dec_valid), 32'd0);
      chk("flush_instr", dec_instr, NOP);
      if (rv_en) exp_pc = rpc;
    end else if (sd) begin
      chk("stall_valid", 32'(dec_valid), 32'(h_valid));
      chk("stall_instr", dec_instr, h_instr);
      chk("stall_pc", dec_pc, h_pc);
    end else if (dec_valid) begin
      chk("stream_pc", dec_pc, exp_pc);
      chk("stream_instr", dec_instr, word_at(dec_pc));
      exp_pc = exp_pc + 32'd4;
      nvalid++;
    end else begin
      chk("bubble_instr", dec_instr, NOP);
    end
    h_valid = dec_valid; h_instr = dec_instr; h_pc = dec_pc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    logic [31:0] a0;
    logic [31:0] rpc;
    bit sf, sd, fd, rd, g;

    // Reset and free run from RESET_VEC
    repeat (2) step(1, 0, 0, 0, 0, '0, 1);
    rel = cyc;
    for (int i = 0; i < 8 && !dec_valid; i++) step(0, 0, 0, 0, 0, '0, 1);
    chk("first_valid_cycle", 32'(cyc - rel), 32'(EXP_LAT));
    chk("first_pc", dec_pc, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, '0, 1);
      chk("back_to_back", 32'(dec_valid), 32'd1);
    end
    chk("fourth_pc", dec_pc, 32'hC);

    // StallF and StallD together freeze fetch and decode
    run(3);
    step(0, 1, 1, 0, 0, '0, 1);
    a0 = obs_addr;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 0, '0, 1);
      chk("stallf_no_req", 32'(obs_req), 32'd0);
      chk("stallf_addr", obs_addr, a0);
    end
    run(6);

    // Slow imem, redirect with stale requests in flight
    lat_lo = 3; lat_hi = 3;
    run(8);
    step(0, 0, 0, 1, 1, 32'h100, 1);
    for (int i = 0; i < 16 && !dec_valid; i++) step(0, 0, 0, 0, 0, '0, 1);
    chk("redirect_first_pc", dec_pc, 32'h100);
    chk("redirect_reached", 32'(dec_valid), 32'd1);
    run(4);

    // Flush wins over stall
    step(0, 0, 1, 1, 0, '0, 1);
    chk("flush_over_stall", 32'(dec_valid), 32'd0);
    run(4);

    // Grant withheld: request must persist, even across a StallF
    lat_lo = 1; lat_hi = 1;
    run(4);
    for (int i = 0; i < 5; i++) begin
      step(0, (i == 2), 0, 0, 0, '0, 0);
      chk("nognt_req", 32'(obs_req), 32'd1);
    end
    run(8);

    // Reset with responses in flight; late responses must be ignored
    lat_lo = 3; lat_hi = 3;
    run(8);
    step(1, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 16 && !dec_valid; i++) step(0, 0, 0, 0, 0, '0, 1);
    chk("reset_restart_pc", dec_pc, 32'd0);
    chk("reset_restart_instr", dec_instr, word_at(32'd0));

    // PC wrap through zero
    lat_lo = 1; lat_hi = 2;
    step(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 1);
    run(12);

    // Randomised hazards, grants and latencies
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      sf = ($urandom_range(99, 0) < 15);
      sd = ($urandom_range(99, 0) < 20);
      g  = ($urandom_range(99, 0) < 70);
      rd = ($urandom_range(99, 0) < 4);
      fd = rd || ($urandom_range(99, 0) < 2);
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      step(0, sf, sd, fd, rd, rpc, g);
    end

    // Drain: the stream must make progress once hazards clear
    nvalid = 0;
    lat_lo = 1; lat_hi = 1;
    run(20);
    chk("drain_progress", 32'(nvalid >= 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
